// File: rtl/btn_debounce_en.sv
// ---------------------------------------------------------------------------
// btn_debounce_en
//
// Debounces a raw mechanical button and produces the d/en pair for a
// downstream enable flip-flop, plus direction strobes.
//
// The raw input is brought into the clock domain by a two-flop synchronizer.
// A four-state FSM then requires the synchronized level to stay at its new
// value for STABLE_CNT consecutive cycles before the change is accepted.
//
// Parameters
//   STABLE_CNT : consecutive synchronized cycles needed to accept a change (1..255)
//   CNT_W      : qualification counter width (must be able to hold STABLE_CNT)
//
// Ports
//   clk      : clock, rising edge
//   rst_a    : asynchronous reset, active low
//   srst     : synchronous clear, active high (synchronizer keeps sampling)
//   btn      : raw, asynchronous, bouncing button input
//   d_out    : debounced level (downstream flop d input)
//   en_pulse : one-cycle strobe on every accepted change (downstream flop en)
//   rise     : one-cycle strobe on an accepted 0->1 change
//   fall     : one-cycle strobe on an accepted 1->0 change
//   busy     : high while a candidate change is being qualified
// ---------------------------------------------------------------------------
module btn_debounce_en #(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst_a,
  input  logic srst,
  input  logic btn,
  output logic d_out,
  output logic en_pulse,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    S_LOW   = 2'd0,
    S_CHK_H = 2'd1,
    S_HIGH  = 2'd2,
    S_CHK_L = 2'd3
  } state_t;

  // Count value at which the next agreeing sample completes qualification.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CNT - 1);
  // With a one-cycle requirement the change is accepted straight from the
  // stable state, without passing through a check state.
  localparam bit DIRECT = (STABLE_CNT == 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             sync1_reg;
  logic             sync2_reg;

  // Two-flop synchronizer. Only the synchronous clear of the FSM is
  // affected by srst; the synchronizer keeps tracking the button.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
    end
  end

  // Qualification FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_reg <= S_LOW;
      cnt_reg   <= '0;
      d_out     <= 1'b0;
      en_pulse  <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
      busy      <= 1'b0;
    end else if (srst) begin
      state_reg <= S_LOW;
      cnt_reg   <= '0;
      d_out     <= 1'b0;
      en_pulse  <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      en_pulse <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      case (state_reg)
        S_LOW: begin
          // In direct mode a change right after a strobe is held off one
          // cycle so strobes can never land on consecutive cycles.
          if (sync2_reg && !(DIRECT && en_pulse)) begin
            if (DIRECT) begin
              state_reg <= S_HIGH;
              d_out     <= 1'b1;
              en_pulse  <= 1'b1;
              rise      <= 1'b1;
            end else begin
              state_reg <= S_CHK_H;
              cnt_reg   <= CNT_W'(1);
              busy      <= 1'b1;
            end
          end
        end
        S_CHK_H: begin
          if (!sync2_reg) begin
            // Glitch: fall back silently.
            state_reg <= S_LOW;
            cnt_reg   <= '0;
            busy      <= 1'b0;
          end else if (cnt_reg == LAST_CNT) begin
            state_reg <= S_HIGH;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            d_out     <= 1'b1;
            en_pulse  <= 1'b1;
            rise      <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        S_HIGH: begin
          if (!sync2_reg && !(DIRECT && en_pulse)) begin
            if (DIRECT) begin
              state_reg <= S_LOW;
              d_out     <= 1'b0;
              en_pulse  <= 1'b1;
              fall      <= 1'b1;
            end else begin
              state_reg <= S_CHK_L;
              cnt_reg   <= CNT_W'(1);
              busy      <= 1'b1;
            end
          end
        end
        S_CHK_L: begin
          if (sync2_reg) begin
            state_reg <= S_HIGH;
            cnt_reg   <= '0;
            busy      <= 1'b0;
          end else if (cnt_reg == LAST_CNT) begin
            state_reg <= S_LOW;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            d_out     <= 1'b0;
            en_pulse  <= 1'b1;
            fall      <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= S_LOW;
          cnt_reg   <= '0;
          d_out     <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_debounce_en.sv
// ---------------------------------------------------------------------------
// tb_btn_debounce_en
//
// Directed bench for btn_debounce_en at STABLE_CNT = 4. Each stimulus step
// queues the output vector {d_out, en_pulse, rise, fall, busy} expected after
// specific rising edges; a monitor compares the queue head on the falling
// edge once the edge count reaches it.
// ---------------------------------------------------------------------------
module tb_btn_debounce_en;

  logic clk;
  logic rst_a;
  logic srst;
  logic btn;
  logic d_out;
  logic en_pulse;
  logic rise;
  logic fall;
  logic busy;

  btn_debounce_en #(
    .STABLE_CNT(4),
    .CNT_W     (8)
  ) dut (
    .clk     (clk),
    .rst_a   (rst_a),
    .srst    (srst),
    .btn     (btn),
    .d_out   (d_out),
    .en_pulse(en_pulse),
    .rise    (rise),
    .fall    (fall),
    .busy    (busy)
  );

  typedef struct {
    int         cyc;
    logic [4:0] v;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_total = 0;
  int   n_pass  = 0;
  logic en_prev = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor, sampled away from the active edge.
  always @(negedge clk) begin
    logic [4:0] obs;
    exp_t       e;
    obs = {d_out, en_pulse, rise, fall, busy};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_total++;
      assert (e.cyc == cyc && obs === e.v) n_pass++;
      else $error("FAIL %s edge=%0d (due %0d): got d/en/rise/fall/busy=%b, want %b",
                  e.tag, cyc, e.cyc, obs, e.v);
    end
    // Strobe hygiene: no back-to-back en_pulse, never rise with fall.
    n_total++;
    assert (!(en_pulse && en_prev) && !(rise && fall)) n_pass++;
    else $error("FAIL strobe_rules edge=%0d: got en=%b prev_en=%b rise=%b fall=%b, want no overlap",
                cyc, en_pulse, en_prev, rise, fall);
    en_prev = en_pulse;
  end

  task automatic push(input int c, input logic [4:0] v, input string tag);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Expected outputs after a stable change was last driven just after edge
  // 'base' (so the first sampling edge is base+1): busy on base+3..base+5,
  // accept and strobe on base+6, quiet at the new level on base+7.
  task automatic push_qual(input int base, input logic hi, input string tag);
    for (int i = 3; i <= 5; i++) push(base + i, {~hi, 4'b0001}, tag);
    push(base + 6, {hi, 1'b1, hi, ~hi, 1'b0}, tag);
    push(base + 7, {hi, 4'b0000}, tag);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_async_zero(input string tag);
    n_total++;
    assert ({d_out, en_pulse, rise, fall, busy} === 5'b00000) n_pass++;
    else $error("FAIL %s: got d/en/rise/fall/busy=%b, want 00000",
                tag, {d_out, en_pulse, rise, fall, busy});
  endtask

  initial begin
    int b;
    rst_a = 1'b1;
    srst  = 1'b0;
    btn   = 1'b0;

    // Asynchronous reset between edges clears outputs before any edge.
    #1 rst_a = 1'b0;
    #2 check_async_zero("reset_async");
    step(3);
    rst_a = 1'b0;
    rst_a = 1'b1;

    // Idle after release with btn low: outputs stay 0.
    b = cyc;
    for (int i = 1; i <= 10; i++) push(b + i, 5'b00000, "idle_low");
    step(10);

    // Clean rise.
    btn = 1'b1;
    b = cyc;
    push(b + 1, 5'b00000, "rise_pre");
    push(b + 2, 5'b00000, "rise_pre");
    push_qual(b, 1'b1, "rise");
    step(10);

    // Fall with 1-cycle bounces, then settle low.
    btn = 1'b0;
    b = cyc;
    push(b + 1, 5'b10000, "bounce");
    push(b + 2, 5'b10000, "bounce");
    push(b + 3, 5'b10001, "bounce");
    push(b + 4, 5'b10000, "bounce");
    push(b + 5, 5'b10001, "bounce");
    push(b + 6, 5'b10000, "bounce");
    step(1); btn = 1'b1;
    step(1); btn = 1'b0;
    step(1); btn = 1'b1;
    step(1); btn = 1'b0;
    push_qual(b + 4, 1'b0, "fall_bounce");
    step(12);

    // Two-cycle glitch: busy pulses, no strobe, no level change.
    btn = 1'b1;
    b = cyc;
    push(b + 1, 5'b00000, "glitch");
    push(b + 2, 5'b00000, "glitch");
    push(b + 3, 5'b00001, "glitch");
    push(b + 4, 5'b00001, "glitch");
    for (int i = 5; i <= 9; i++) push(b + i, 5'b00000, "glitch");
    step(2);
    btn = 1'b0;
    step(10);

    // Rise again, then synchronous clear while high.
    btn = 1'b1;
    b = cyc;
    push(b + 1, 5'b00000, "rise2_pre");
    push(b + 2, 5'b00000, "rise2_pre");
    push_qual(b, 1'b1, "rise2");
    step(10);
    srst = 1'b1;
    b = cyc;
    push(b + 1, 5'b00000, "srst_clear");
    push_qual(b - 1, 1'b1, "srst_requal");
    step(1);
    srst = 1'b0;
    step(10);

    // Clean fall.
    btn = 1'b0;
    b = cyc;
    push(b + 1, 5'b10000, "fall_pre");
    push(b + 2, 5'b10000, "fall_pre");
    push_qual(b, 1'b0, "fall");
    step(10);

    // Asynchronous reset in the middle of qualifying a rise.
    btn = 1'b1;
    b = cyc;
    push(b + 1, 5'b00000, "abort_pre");
    push(b + 2, 5'b00000, "abort_pre");
    push(b + 3, 5'b00001, "abort_chk");
    step(3);
    @(negedge clk);
    #1 rst_a = 1'b0;
    #1 check_async_zero("reset_mid_qual");
    push(b + 4, 5'b00000, "abort_rst");
    push(b + 5, 5'b00000, "abort_rst");
    repeat (2) @(posedge clk);
    #2 rst_a = 1'b1;
    b = cyc;
    push(b + 1, 5'b00000, "post_rst_pre");
    push(b + 2, 5'b00000, "post_rst_pre");
    push_qual(b, 1'b1, "post_rst_rise");
    step(12);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    n_total++;
    assert (sb.size() == 0) n_pass++;
    else $error("FAIL sb_drain: got %0d pending entries, want 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/btn_debounce_en.md
BTN_DEBOUNCE_EN -- requirements
Module: btn_debounce_en

Interface
REQ-001 Parameter STABLE_CNT, default 4, SHALL be the consecutive synchronized-cycle count required to accept a level change; legal range 1..255.
REQ-002 Parameter CNT_W, default 8, SHALL be the qualification counter width; CNT_W SHALL hold STABLE_CNT.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_a  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 srst  input  1  SHALL be the synchronous clear, active-high.
REQ-006 btn  input  1  SHALL be the raw asynchronous, bouncing input.
REQ-007 d_out  output  1  SHALL be the debounced level; drives the downstream flip-flop d input.
REQ-008 en_pulse  output  1  SHALL be a one-cycle strobe on every accepted change; drives the downstream flip-flop en input.
REQ-009 rise  output  1  SHALL be a one-cycle strobe on an accepted 0->1 change.
REQ-010 fall  output  1  SHALL be a one-cycle strobe on an accepted 1->0 change.
REQ-011 busy  output  1  SHALL be high while a change is being qualified.

Function
REQ-012 btn SHALL pass through a 2-flop synchronizer (sync1 -> sync2); only sync2 feeds the FSM.
REQ-013 FSM states SHALL be S_LOW, S_CHK_H, S_HIGH and S_CHK_L, with a counter cnt.
REQ-014 S_LOW with sync2=1 SHALL go to S_CHK_H with cnt=1; otherwise S_LOW SHALL hold.
REQ-015 S_CHK_H with sync2=0 SHALL return to S_LOW with cnt=0 and no strobe, rejecting the glitch.
REQ-016 S_CHK_H with sync2=1 SHALL increment cnt; when the increment would reach STABLE_CNT, it SHALL go to S_HIGH and clear cnt.
REQ-017 The S_HIGH / S_CHK_L path SHALL mirror REQ-014..016 with sync2 inverted.
REQ-018 If STABLE_CNT=1, the transition SHALL occur directly from S_LOW/S_HIGH, with no S_CHK dwell.
REQ-019 All outputs SHALL be registered.
REQ-020 d_out SHALL equal 1 exactly in S_HIGH and S_CHK_L.
REQ-021 On entering S_HIGH: en_pulse=1 and rise=1 for exactly one cycle.
REQ-022 On entering S_LOW from S_CHK_L: en_pulse=1 and fall=1 for exactly one cycle.
REQ-023 busy SHALL be 1 exactly in S_CHK_H and S_CHK_L.
REQ-024 Latency: if edge k first samples a stable btn change into sync1, d_out and the strobe SHALL update at edge k+1+STABLE_CNT (k+5 at default).
REQ-025 A change held fewer than STABLE_CNT synchronized cycles SHALL produce no strobe and no d_out change.
REQ-026 rise, fall and en_pulse SHALL never be high in consecutive cycles; rise and fall SHALL never be high together.
REQ-027 cnt SHALL never exceed STABLE_CNT-1 and SHALL never wrap.
REQ-028 Priority SHALL be rst_a > srst > FSM.
REQ-029 srst=1 at an edge SHALL force S_LOW, cnt=0, d_out=0 and all strobes 0; no fall strobe is generated, and sync1/sync2 keep sampling.

Reset
REQ-030 rst_a=0 SHALL immediately, without waiting for clk, force sync1=sync2=0, state S_LOW, cnt=0, and d_out=en_pulse=rise=fall=busy=0.
REQ-031 Reset asserted mid-qualification SHALL abort it with no strobe.
REQ-032 If btn=1 at rst_a release, normal qualification SHALL follow and produce a rise strobe.

Verification
REQ-033 rst_a=0 asserted between edges -> all outputs 0 before the next edge; release with btn=0 for 10 cycles -> outputs stay 0.
REQ-034 btn 0->1 held 10 cycles, STABLE_CNT=4 -> d_out=1, en_pulse=rise=1 for one cycle at edge k+5; busy=1 during edges k+2..k+4.
REQ-035 btn high for 2 cycles then low (glitch) -> busy pulses, with no d_out change and no strobe.
REQ-036 From d_out=1, btn falls and bounces (1-cycle highs) then settles low -> exactly one fall/en_pulse, timed STABLE_CNT synchronized cycles after the last bounce.
REQ-037 srst=1 with d_out=1 and btn=1 -> next edge d_out=0 with no strobe; after srst release -> rise strobe after requalification.
REQ-038 rst_a pulsed low during S_CHK_H -> no strobe; with btn still high, rise at edge k+5 counted from release.
